// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Arbitrates two requesters for a single UART output handler. The winner's
//   payload is latched into the hdl_* registers. The handler gets a one-cycle
//   start pulse, and the arbiter waits for the handler's done pulse, bounded
//   by a timeout. A one-cycle ack goes back to the requester that was served,
//   together with timeout_err when the handler never finished.
//
// Configuration:
//   UART_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//                             between the two requesters. When undefined,
//                             req0 always has priority over req1.
//
// Parameters:
//   TIMEOUT_CYCLES  - maximum number of cycles spent waiting for hdl_finished
//
// Ports:
//   clk             - clock, all state on the rising edge
//   rst             - asynchronous reset, active low
//   req0/req1       - transaction requests, held high until the matching ack
//   reqN_status     - per-requester status word (valid while reqN is high)
//   reqN_address    - per-requester address word
//   reqN_data       - per-requester data word
//   reqN_data_count - per-requester extra data word count
//   ack0/ack1       - one-cycle completion pulse to the served requester
//   timeout_err     - one-cycle pulse, coincident with the ack, on timeout
//   hdl_status/address/data/data_count - latched payload to the handler
//   hdl_send_en     - one-cycle start pulse to the handler
//   hdl_ready       - handler ready level
//   hdl_finished    - handler done pulse (only honoured while waiting)
//   grant           - index of the requester being served
//   busy            - high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] req0_status,
    input  logic [31:0] req0_address,
    input  logic [31:0] req0_data,
    input  logic [15:0] req0_data_count,
    input  logic [31:0] req1_status,
    input  logic [31:0] req1_address,
    input  logic [31:0] req1_data,
    input  logic [15:0] req1_data_count,
    output logic        ack0,
    output logic        ack1,
    output logic        timeout_err,
    output logic [31:0] hdl_status,
    output logic [31:0] hdl_address,
    output logic [31:0] hdl_data,
    output logic [15:0] hdl_data_count,
    output logic        hdl_send_en,
    input  logic        hdl_ready,
    input  logic        hdl_finished,
    output logic        grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Timer value on which the wait is abandoned.
    localparam logic [23:0] TIMER_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t      state;
    logic [23:0] timer;
    logic        winner;

    // The timer holds at all-ones rather than wrapping, so a very large
    // TIMEOUT_CYCLES can never be skipped past by a wrap-around.
    function automatic logic [23:0] sat_inc(input logic [23:0] value);
        return (value == 24'hFFFFFF) ? value : value + 24'd1;
    endfunction

`ifdef UART_ARB_ROUND_ROBIN_EN
    // Index of the requester preferred on the next simultaneous request.
    logic rr_ptr;

    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = rr_ptr;
        end else begin
            winner = req1;
        end
    end
`else
    // Fixed priority: req1 wins only when req0 is absent.
    always_comb begin
        winner = !req0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            timer          <= 24'd0;
            grant          <= 1'b0;
            busy           <= 1'b0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            timeout_err    <= 1'b0;
            hdl_send_en    <= 1'b0;
            hdl_status     <= 32'd0;
            hdl_address    <= 32'd0;
            hdl_data       <= 32'd0;
            hdl_data_count <= 16'd0;
`ifdef UART_ARB_ROUND_ROBIN_EN
            rr_ptr         <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; each is raised for exactly one
            // cycle by the transition that owns it.
            hdl_send_en <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant          <= winner;
                        hdl_status     <= winner ? req1_status     : req0_status;
                        hdl_address    <= winner ? req1_address    : req0_address;
                        hdl_data       <= winner ? req1_data       : req0_data;
                        hdl_data_count <= winner ? req1_data_count : req0_data_count;
                        busy           <= 1'b1;
                        state          <= SEND;
                    end
                end

                SEND: begin
                    if (hdl_ready) begin
                        hdl_send_en <= 1'b1;
                        timer       <= 24'd0;
                        state       <= WAIT;
                    end
                end

                WAIT: begin
                    timer <= sat_inc(timer);
                    // The ack and error pulses are raised on entry to DONE
                    // so they are visible during the DONE cycle itself.
                    // A finish arriving on the timeout cycle takes precedence.
                    if (hdl_finished) begin
                        ack0  <= !grant;
                        ack1  <= grant;
                        state <= DONE;
                    end else if (timer == TIMER_LAST) begin
                        ack0        <= !grant;
                        ack1        <= grant;
                        timeout_err <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef UART_ARB_ROUND_ROBIN_EN
                    rr_ptr <= !grant;
`endif
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter built with TIMEOUT_CYCLES = 16.
// It applies a table of directed transactions, a reset-in-flight sequence and
// a randomized phase. The reference model works at the transaction level:
// which requester wins, which payload must appear, on which cycle the start
// pulse, the ack and the timeout must appear, and what the arbitration
// pointer becomes afterwards.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] req0_status, req0_address, req0_data;
    logic [15:0] req0_data_count;
    logic [31:0] req1_status, req1_address, req1_data;
    logic [15:0] req1_data_count;
    logic        ack0, ack1, timeout_err;
    logic [31:0] hdl_status, hdl_address, hdl_data;
    logic [15:0] hdl_data_count;
    logic        hdl_send_en;
    logic        hdl_ready, hdl_finished;
    logic        grant, busy;

    int errors = 0;
    int checks = 0;

    // Model state: requester preferred on the next simultaneous request.
    logic rr_m = 1'b0;

    typedef struct {
        logic [31:0] st;
        logic [31:0] ad;
        logic [31:0] dt;
        logic [15:0] cnt;
    } pay_t;

    typedef struct {
        logic        r0;
        logic        r1;
        int          lag;
        int          fin;
        bit          scr;
        logic [31:0] st;
        logic [31:0] ad;
        logic [31:0] dt;
        logic        g_fix;
        logic        g_rr;
    } vec_t;

    vec_t tbl[9];

    uart_tx_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0            (req0),
        .req1            (req1),
        .req0_status     (req0_status),
        .req0_address    (req0_address),
        .req0_data       (req0_data),
        .req0_data_count (req0_data_count),
        .req1_status     (req1_status),
        .req1_address    (req1_address),
        .req1_data       (req1_data),
        .req1_data_count (req1_data_count),
        .ack0            (ack0),
        .ack1            (ack1),
        .timeout_err     (timeout_err),
        .hdl_status      (hdl_status),
        .hdl_address     (hdl_address),
        .hdl_data        (hdl_data),
        .hdl_data_count  (hdl_data_count),
        .hdl_send_en     (hdl_send_en),
        .hdl_ready       (hdl_ready),
        .hdl_finished    (hdl_finished),
        .grant           (grant),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pay(input string tag, input pay_t ep);
        check($sformatf("%s.hdl_status", tag), 64'(hdl_status), 64'(ep.st));
        check($sformatf("%s.hdl_address", tag), 64'(hdl_address), 64'(ep.ad));
        check($sformatf("%s.hdl_data", tag), 64'(hdl_data), 64'(ep.dt));
        check($sformatf("%s.hdl_data_count", tag), 64'(hdl_data_count), 64'(ep.cnt));
    endtask

    task automatic scramble();
        req0_status     = $urandom;
        req0_address    = $urandom;
        req0_data       = $urandom;
        req0_data_count = 16'($urandom);
        req1_status     = $urandom;
        req1_address    = $urandom;
        req1_data       = $urandom;
        req1_data_count = 16'($urandom);
    endtask

    // Spec rule for choosing the winner among the requests present at sampling.
    function automatic logic model_winner(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef UART_ARB_ROUND_ROBIN_EN
            return rr_m;
`else
            return 1'b0;
`endif
        end
        return r0 ? 1'b0 : 1'b1;
    endfunction

    // One complete transaction, started with the DUT idle just after an edge.
    //   lag : cycles hdl_ready stays low after the grant
    //   fin : WAIT cycle (1-based) on which hdl_finished is pulsed; > TMO = never
    //   scr : scramble payloads and hdl_ready while the transaction is in flight
    task automatic txn(input logic r0, input logic r1, input int lag, input int fin,
                       input bit scr, input logic ew, input string tag);
        pay_t ep;
        bit   done;
        if (ew) ep = '{req1_status, req1_address, req1_data, req1_data_count};
        else    ep = '{req0_status, req0_address, req0_data, req0_data_count};
        req0 = r0;
        req1 = r1;
        hdl_ready = (lag == 0);
        hdl_finished = 1'b0;

        @(posedge clk); #1;
        check($sformatf("%s.grant", tag), 64'(grant), 64'(ew));
        check($sformatf("%s.busy_grant", tag), 64'(busy), 64'd1);
        check($sformatf("%s.send_en_grant", tag), 64'(hdl_send_en), 64'd0);
        check_pay($sformatf("%s.latched", tag), ep);

        // Handler not ready: no start pulse; a stray finish is ignored.
        for (int c = 1; c <= lag; c++) begin
            @(negedge clk);
            if (scr) scramble();
            hdl_finished = (c == 1);
            @(posedge clk); #1;
            check($sformatf("%s.send_en_held", tag), 64'(hdl_send_en), 64'd0);
            check($sformatf("%s.busy_held", tag), 64'(busy), 64'd1);
        end

        @(negedge clk);
        hdl_finished = 1'b0;
        hdl_ready = 1'b1;
        if (scr) scramble();
        @(posedge clk); #1;
        check($sformatf("%s.send_en", tag), 64'(hdl_send_en), 64'd1);
        check($sformatf("%s.ack_at_send", tag), 64'({ack0, ack1}), 64'd0);

        done = 1'b0;
        for (int k = 1; k <= TMO && !done; k++) begin
            @(negedge clk);
            hdl_finished = (k == fin);
            if (scr) begin
                scramble();
                hdl_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            done = (k == fin) || (k == TMO);
            check($sformatf("%s.send_en_wait", tag), 64'(hdl_send_en), 64'd0);
            check($sformatf("%s.busy_wait", tag), 64'(busy), 64'd1);
            check($sformatf("%s.ack0", tag), 64'(ack0), 64'(done && !ew));
            check($sformatf("%s.ack1", tag), 64'(ack1), 64'(done && ew));
            check($sformatf("%s.timeout_err", tag), 64'(timeout_err), 64'(done && fin > TMO));
            check_pay($sformatf("%s.stable", tag), ep);
        end

        // Requester drops its req once it has seen the ack.
        @(negedge clk);
        hdl_finished = 1'b0;
        if (ew) req1 = 1'b0;
        else    req0 = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s.busy_end", tag), 64'(busy), 64'd0);
        check($sformatf("%s.pulses_end", tag), 64'({ack0, ack1, timeout_err}), 64'd0);
        rr_m = !ew;
    endtask

    initial begin
        logic eg;
        logic pend0, pend1;

        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        hdl_ready = 1'b0;
        hdl_finished = 1'b0;
        scramble();

        //            r0 r1 lag fin scr status     address     data        fix rr
        tbl[0] = '{1'b1, 1'b1, 0,  2, 1'b0, 32'h100, 32'h200, 32'h300, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 0,  3, 1'b0, 32'h101, 32'h201, 32'h301, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 0,  1, 1'b0, 32'h1,   32'h10,  32'hCAFE, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 50, 5, 1'b0, 32'h103, 32'h203, 32'h303, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 0, 99, 1'b0, 32'h104, 32'h204, 32'h304, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 0,  2, 1'b0, 32'h105, 32'h205, 32'h305, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1,  8, 1'b1, 32'h106, 32'h206, 32'h306, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 0, 16, 1'b0, 32'h107, 32'h207, 32'h307, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 2,  4, 1'b0, 32'h108, 32'h208, 32'h308, 1'b0, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.grant", 64'(grant), 64'd0);
        check("reset.pulses", 64'({ack0, ack1, timeout_err, hdl_send_en}), 64'd0);
        check("reset.payload", {hdl_status, hdl_address} | 64'(hdl_data) | 64'(hdl_data_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle.busy", 64'(busy), 64'd0);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            req0_status     = tbl[i].st;
            req0_address    = tbl[i].ad;
            req0_data       = tbl[i].dt;
            req0_data_count = 16'(i);
            req1_status     = ~tbl[i].st;
            req1_address    = ~tbl[i].ad;
            req1_data       = ~tbl[i].dt;
            req1_data_count = 16'hF000 | 16'(i);
`ifdef UART_ARB_ROUND_ROBIN_EN
            eg = tbl[i].g_rr;
`else
            eg = tbl[i].g_fix;
`endif
            txn(tbl[i].r0, tbl[i].r1, tbl[i].lag, tbl[i].fin, tbl[i].scr, eg,
                $sformatf("vec%0d", i));
        end

        // Reset while waiting on the handler: transaction aborted, no ack.
        req0 = 1'b0;
        req1 = 1'b1;
        hdl_ready = 1'b1;
        @(posedge clk); #1;
        check("abort.grant", 64'(grant), 64'd1);
        @(posedge clk); #1;
        check("abort.send_en", 64'(hdl_send_en), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort.busy_async", 64'(busy), 64'd0);
        check("abort.send_en_async", 64'(hdl_send_en), 64'd0);
        check("abort.grant_async", 64'(grant), 64'd0);
        check("abort.payload_async", 64'(hdl_status) | 64'(hdl_data), 64'd0);
        hdl_finished = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("abort.no_ack", 64'({ack0, ack1, timeout_err}), 64'd0);
            check("abort.busy_in_reset", 64'(busy), 64'd0);
        end
        @(negedge clk);
        hdl_finished = 1'b0;
        req1 = 1'b0;
        rst = 1'b1;
        rr_m = 1'b0;
        @(posedge clk); #1;
        check("abort.no_ack_after", 64'({ack0, ack1, busy}), 64'd0);
        txn(1'b0, 1'b1, 0, 3, 1'b0, 1'b1, "post_rst_req1");
        rr_m = model_winner(1'b1, 1'b1);
        txn(1'b1, 1'b1, 0, 2, 1'b0, model_winner(1'b1, 1'b1), "post_rst_both");

        // Randomized transactions against the model.
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!pend0) pend0 = 1'($urandom);
            if (!pend1) pend1 = 1'($urandom);
            if (!pend0 && !pend1) pend0 = 1'b1;
            scramble();
            eg = model_winner(pend0, pend1);
            txn(pend0, pend1, int'($urandom_range(0, 3)), int'($urandom_range(1, 20)),
                1'($urandom), eg, $sformatf("rand%0d", n));
            if (eg) pend1 = 1'b0;
            else    pend0 = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 24'd1000000, which sets the maximum number of cycles spent waiting for hdl_finished.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: transaction requests; a requester holds its req high until its ack.
REQ-005 The block SHALL have ports req0_status, req0_address, req0_data, req1_status, req1_address, req1_data, input, 32 bits each: per-requester payloads, valid while req is high.
REQ-006 The block SHALL have ports req0_data_count and req1_data_count, input, 16 bits each: number of extra data words.
REQ-007 The block SHALL have ports ack0 and ack1, output, 1 bit each: one-cycle completion pulses.
REQ-008 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse, coincident with the ack, when the transaction timed out.
REQ-009 The block SHALL have ports hdl_status, hdl_address, hdl_data, output, 32 bits each, and hdl_data_count, output, 16 bits: the latched payload driven to the UART output handler.
REQ-010 The block SHALL have port hdl_send_en, output, 1 bit: one-cycle start pulse to the handler.
REQ-011 The block SHALL have ports hdl_ready and hdl_finished, input, 1 bit each: handler ready level and handler done pulse.
REQ-012 The block SHALL have port grant, output, 1 bit: index of the requester being served; port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SEND, WAIT and DONE.
REQ-014 In IDLE with any req high, the block SHALL pick a winner (REQ-024), latch its payload into the hdl_* registers, set grant, and move to SEND on the same edge.
REQ-015 In SEND with hdl_ready high, the block SHALL pulse hdl_send_en for exactly one cycle, clear the timer and move to WAIT; while hdl_ready is low it SHALL stay in SEND indefinitely.
REQ-016 In WAIT, the timer SHALL increment every cycle; on hdl_finished the block SHALL move to DONE.
REQ-017 In WAIT, when the timer reaches TIMEOUT_CYCLES-1 without hdl_finished, the block SHALL set a timeout flag and move to DONE; if hdl_finished and timeout occur in the same cycle, finished SHALL win (no error).
REQ-018 In DONE, the block SHALL assert ack[grant] for one cycle, assert timeout_err in the same cycle if the flag is set, then return to IDLE.
REQ-019 Requests SHALL be sampled only in IDLE; req changes and payload changes outside IDLE SHALL be ignored.
REQ-020 The hdl_* payload outputs SHALL be stable from SEND through DONE.
REQ-021 Latency from req to hdl_send_en SHALL be 2 cycles when hdl_ready is already high.
REQ-022 The timer SHALL be 24 bits and saturating; hdl_finished seen outside WAIT SHALL be ignored.

Reset
REQ-023 While rst is low, the block SHALL go to IDLE asynchronously and clear all outputs, the timer, the timeout flag and the round-robin pointer to 0, including when reset arrives mid-transaction; no ack SHALL be issued for an aborted transaction.

Configuration
REQ-024 With macro UART_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the block SHALL grant the requester not served last (pointer toggles after each DONE); without the macro, req0 SHALL always have fixed priority over req1.

Verification
REQ-025 Directed scenario: req0 alone, status=32'h1, address=32'h10, data=32'hCAFE, hdl_ready=1 -> hdl_send_en 2 cycles later with those payload values; hdl_finished -> ack0 one cycle later; timeout_err=0.
REQ-026 Directed scenario: req0 and req1 asserted in the same cycle, twice back-to-back -> without the macro grant sequence 0,0; with UART_ARB_ROUND_ROBIN_EN grant sequence 0,1.
REQ-027 Directed scenario: hdl_ready held low 50 cycles after grant -> block stays in SEND with no hdl_send_en; one pulse when hdl_ready rises.
REQ-028 Directed scenario: TIMEOUT_CYCLES=16, hdl_finished never arrives -> ack and timeout_err pulse together; next request is served normally.
REQ-029 Directed scenario: rst driven low in WAIT -> busy=0 and hdl_send_en=0 immediately; no ack; a fresh req1 after reset is granted.
REQ-030 Directed scenario: req1 payload changed during WAIT -> hdl_* outputs hold the values latched in IDLE.
